// File: rtl/vga_text_mode_gen_if.sv
// Character/attribute read port and glyph font port of the text-mode generator.
// The master side sits in the generator; the slave side is the CSR memory and the font ROM.
interface vga_text_mode_gen_if #(
    parameter int AW = 16
) ();
    logic [AW-1:0] csr_adr_o;
    logic          csr_stb_o;
    logic          csr_ack_i;
    logic [15:0]   csr_dat_i;
    logic [12:0]   font_adr_o;
    logic [7:0]    font_dat_i;

    modport master (
        output csr_adr_o, csr_stb_o, font_adr_o,
        input  csr_ack_i, csr_dat_i, font_dat_i
    );
    modport slave (
        input  csr_adr_o, csr_stb_o, font_adr_o,
        output csr_ack_i, csr_dat_i, font_dat_i
    );
endinterface

// File: rtl/vga_text_mode_gen.sv
// Text-mode pixel generator: fetches char/attr per cell, looks up the glyph row,
// and shifts out 4-bit colour indices W+1 cycles behind the CRTC counters.
module vga_text_mode_gen #(
    parameter int COLS   = 80,
    parameter int ROWS   = 25,
    parameter int CHAR_H = 16,
    parameter int HW     = 10,
    parameter int AW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [HW-1:0] h_count,
    input  logic [HW-1:0] v_count,
    input  logic          horiz_sync_i,
    input  logic          video_on_h_i,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] cursor_pos,
    input  logic [4:0]    cur_start,
    input  logic [4:0]    cur_end,
    input  logic          dot9,
    input  logic          blink_en,
    vga_text_mode_gen_if.master bus,
    output logic [3:0]    attr,
    output logic          horiz_sync_o,
    output logic          video_on_h_o,
    output logic          underrun_o
);
    localparam logic [HW-1:0] COLS_H    = HW'(COLS);
    localparam logic [HW-1:0] ROWS_H    = HW'(ROWS);
    localparam logic [AW-1:0] COLS_A    = AW'(COLS);
    localparam logic [4:0]    SCAN_LAST = 5'(CHAR_H - 1);

    logic [3:0]    dc_q, dc_c, dc_d, dc_last, dc_dead;
    logic [HW-1:0] col_q, col_c, col_d, row_q, row_d;
    logic [4:0]    scan_q, scan_d;
    logic [AW-1:0] lb_q, lb_d;
    logic          dot9_q, blink_q;
    logic [4:0]    fc_q;
    logic          line_start, frame_start, w9, in_win, ack_ok, cur_row, ninth;

    logic          stb_q, got_q, hit_q, underrun_q;
    logic [AW-1:0] adr_q;
    logic [7:0]    char_q, cattr_q;
    logic [12:0]   fadr_q;

    logic [8:0]    sh_q;
    logic [7:0]    dattr_q;
    logic          dcur_q, pix;
    logic [3:0]    fg, bg, attr_q;
    logic [8:0]    hs_pipe_q, vo_pipe_q;
    logic          hs_q, vo_q;

    // The _d line values double as the live values during the h_count==0 cycle,
    // so the first cell of a line already fetches from the new address.
    always_comb begin
        line_start  = (h_count == '0);
        frame_start = line_start && (v_count == '0);
        w9          = frame_start ? dot9 : dot9_q;
        dc_last     = w9 ? 4'd8 : 4'd7;
        dc_dead     = w9 ? 4'd6 : 4'd5;
        dc_c        = line_start ? '0 : dc_q;
        col_c       = line_start ? '0 : col_q;
        dc_d        = (dc_c == dc_last) ? '0 : dc_c + 4'd1;
        col_d       = (dc_c == dc_last) ? col_c + 1'b1 : col_c;
        scan_d      = scan_q;
        row_d       = row_q;
        lb_d        = lb_q;
        if (frame_start) begin
            scan_d = '0;
            row_d  = '0;
            lb_d   = start_addr;
        end else if (line_start) begin
            if (scan_q == SCAN_LAST) begin
                scan_d = '0;
                row_d  = row_q + 1'b1;
                lb_d   = lb_q + COLS_A;
            end else begin
                scan_d = scan_q + 5'd1;
            end
        end
        in_win  = (col_c < COLS_H) && (row_d < ROWS_H);
        ack_ok  = stb_q && bus.csr_ack_i;
        cur_row = (cur_start <= scan_d) && (scan_d <= cur_end);
        ninth   = w9 && (char_q[7:5] == 3'b110) && bus.font_dat_i[0];
        pix     = sh_q[8] ^ dcur_q;
        bg      = blink_q ? {1'b0, dattr_q[6:4]} : dattr_q[7:4];
        fg      = (blink_q && dattr_q[7] && !fc_q[4]) ? bg : dattr_q[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_q    <= '0;
            col_q   <= '0;
            scan_q  <= '0;
            row_q   <= '0;
            lb_q    <= '0;
            dot9_q  <= 1'b0;
            blink_q <= 1'b0;
            fc_q    <= '0;
        end else if (enable) begin
            dc_q   <= dc_d;
            col_q  <= col_d;
            scan_q <= scan_d;
            row_q  <= row_d;
            lb_q   <= lb_d;
            if (frame_start) begin
                dot9_q  <= dot9;
                blink_q <= blink_en;
                fc_q    <= fc_q + 5'd1;
            end
        end
    end

    // Fetch: strobe from dc==1, dropped after the ack or after the dc==W-3 deadline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q      <= 1'b0;
            got_q      <= 1'b0;
            hit_q      <= 1'b0;
            underrun_q <= 1'b0;
            adr_q      <= '0;
            char_q     <= '0;
            cattr_q    <= '0;
            fadr_q     <= '0;
        end else if (enable) begin
            if (dc_c == '0) begin
                stb_q <= in_win;
                got_q <= 1'b0;
                adr_q <= lb_d + AW'(col_c);
            end else if (ack_ok) begin
                stb_q   <= 1'b0;
                got_q   <= 1'b1;
                char_q  <= bus.csr_dat_i[7:0];
                cattr_q <= bus.csr_dat_i[15:8];
                hit_q   <= (adr_q == cursor_pos);
                fadr_q  <= {bus.csr_dat_i[7:0], scan_d};
            end else if (stb_q && dc_c == dc_dead) begin
                stb_q      <= 1'b0;
                underrun_q <= 1'b1;
            end
        end
    end

    // A cell that missed its fetch is shown as glyph 0 / attr 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q      <= '0;
            dattr_q   <= '0;
            dcur_q    <= 1'b0;
            attr_q    <= '0;
            hs_pipe_q <= '0;
            vo_pipe_q <= '0;
            hs_q      <= 1'b0;
            vo_q      <= 1'b0;
        end else if (enable) begin
            if (dc_c == dc_last) begin
                sh_q    <= got_q ? {bus.font_dat_i, ninth} : 9'd0;
                dattr_q <= got_q ? cattr_q : 8'd0;
                dcur_q  <= got_q && hit_q && cur_row && fc_q[3];
            end else begin
                sh_q <= {sh_q[7:0], 1'b0};
            end
            attr_q    <= pix ? fg : bg;
            hs_pipe_q <= {hs_pipe_q[7:0], horiz_sync_i};
            vo_pipe_q <= {vo_pipe_q[7:0], video_on_h_i};
            hs_q      <= w9 ? hs_pipe_q[8] : hs_pipe_q[7];
            vo_q      <= w9 ? vo_pipe_q[8] : vo_pipe_q[7];
        end
    end

    assign bus.csr_adr_o  = adr_q;
    assign bus.csr_stb_o  = stb_q;
    assign bus.font_adr_o = fadr_q;
    assign attr           = attr_q;
    assign horiz_sync_o   = hs_q;
    assign video_on_h_o   = vo_q;
    assign underrun_o     = underrun_q;
endmodule

// File: tb/tb_vga_text_mode_gen.sv
// Directed bench for the text-mode generator: drives short 48-pixel lines and
// checks captured pixels, strobes and delayed syncs against hand-computed values.
module tb_vga_text_mode_gen;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b1;
    logic [9:0]  hc = '0, vc = '0;
    logic        hs_i = 1'b0, vo_i = 1'b0, dot9 = 1'b0, blink_en = 1'b0;
    logic [15:0] start_addr = '0, cursor_pos = 16'hFFFF;
    logic [4:0]  cur_start = 5'd14, cur_end = 5'd15;
    logic [3:0]  attr;
    logic        hs_o, vo_o, underrun;
    logic [7:0]  glyph_v = 8'h00;
    int          total = 0, bad = 0, fc_m = 0, wl = 8, ack_at = 1;
    logic [3:0]  cap_attr [0:48];
    logic        cap_stb  [0:48];
    logic [15:0] cap_adr  [0:48];
    logic        cap_hs   [0:48];
    logic        cap_vo   [0:48];

    vga_text_mode_gen_if bus ();

    vga_text_mode_gen #(.COLS(80), .ROWS(3), .CHAR_H(16), .HW(10), .AW(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .h_count(hc), .v_count(vc),
        .horiz_sync_i(hs_i), .video_on_h_i(vo_i), .start_addr(start_addr),
        .cursor_pos(cursor_pos), .cur_start(cur_start), .cur_end(cur_end),
        .dot9(dot9), .blink_en(blink_en), .bus(bus.master), .attr(attr),
        .horiz_sync_o(hs_o), .video_on_h_o(vo_o), .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    // Font ROM model: one-cycle read latency.
    always_ff @(posedge clk) bus.font_dat_i <= glyph_v;

    initial begin
        bus.csr_ack_i = 1'b0;
        bus.csr_dat_i = 16'h0000;
    end

    // cap_*[k] holds the output value during the cycle in which h_count was k.
    task automatic run_line(input int v);
        if (v == 0) begin
            fc_m++;
            wl = dot9 ? 9 : 8;
        end
        for (int h = 0; h < 48; h++) begin
            hc = 10'(h);
            vc = 10'(v);
            hs_i = (h == 5);
            vo_i = (h >= 4 && h < 30);
            bus.csr_ack_i = ((h % wl) == ack_at);
            @(posedge clk);
            #1;
            cap_attr[h+1] = attr;
            cap_stb[h+1]  = bus.csr_stb_o;
            cap_adr[h+1]  = bus.csr_adr_o;
            cap_hs[h+1]   = hs_o;
            cap_vo[h+1]   = vo_o;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (attr !== 4'd0) begin bad++; $display("FAIL reset_attr got=%0d want=0", attr); end
        total++; if (bus.csr_stb_o !== 1'b0) begin bad++; $display("FAIL reset_stb got=%0b want=0", bus.csr_stb_o); end
        total++; if (bus.csr_adr_o !== 16'h0) begin bad++; $display("FAIL reset_adr got=%0h want=0", bus.csr_adr_o); end
        total++; if (bus.font_adr_o !== 13'h0) begin bad++; $display("FAIL reset_fadr got=%0h want=0", bus.font_adr_o); end
        total++; if ({hs_o, vo_o, underrun} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {hs_o, vo_o, underrun}); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] e;
        dot9 = 1'b0; blink_en = 1'b0; start_addr = '0; cursor_pos = 16'hFFFF;
        bus.csr_dat_i = 16'h1E41; glyph_v = 8'h81; ack_at = 1;
        run_line(0);
        for (int j = 0; j < 8; j++) begin
            e = (j == 0 || j == 7) ? 4'd14 : 4'd1;
            total++; if (cap_attr[17+j] !== e) begin bad++; $display("FAIL basic_pix%0d got=%0d want=%0d", j, cap_attr[17+j], e); end
        end
        total++; if ({cap_stb[8], cap_stb[9], cap_stb[10]} !== 3'b010) begin bad++; $display("FAIL basic_stb got=%b want=010", {cap_stb[8], cap_stb[9], cap_stb[10]}); end
        total++; if (cap_adr[9] !== 16'h0001) begin bad++; $display("FAIL basic_adr1 got=%0h want=1", cap_adr[9]); end
        total++; if (cap_adr[25] !== 16'h0003) begin bad++; $display("FAIL basic_adr3 got=%0h want=3", cap_adr[25]); end
        total++; if ({cap_hs[13], cap_hs[14], cap_hs[15]} !== 3'b010) begin bad++; $display("FAIL hsync_delay9 got=%b want=010", {cap_hs[13], cap_hs[14], cap_hs[15]}); end
        total++; if ({cap_vo[12], cap_vo[13], cap_vo[38], cap_vo[39]} !== 4'b0110) begin bad++; $display("FAIL video_on_delay got=%b want=0110", {cap_vo[12], cap_vo[13], cap_vo[38], cap_vo[39]}); end
        total++; if (bus.font_adr_o !== {8'h41, 5'd0}) begin bad++; $display("FAIL basic_fadr got=%0h want=%0h", bus.font_adr_o, {8'h41, 5'd0}); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL basic_underrun got=%0b want=0", underrun); end
    endtask

    task automatic test_scroll();
        logic any_stb, any_pix;
        start_addr = 16'h0050;
        for (int v = 0; v <= 32; v++) run_line(v);
        total++; if (cap_adr[25] !== 16'h00F3) begin bad++; $display("FAIL scroll_adr got=%0h want=f3", cap_adr[25]); end
        start_addr = 16'hFFF0;
        for (int v = 0; v <= 48; v++) begin
            run_line(v);
            if (v == 32) begin
                total++; if (cap_adr[25] !== 16'h0093) begin bad++; $display("FAIL scroll_wrap got=%0h want=93", cap_adr[25]); end
            end
        end
        any_stb = 1'b0; any_pix = 1'b0;
        for (int k = 1; k <= 48; k++) any_stb |= cap_stb[k];
        for (int k = 9; k <= 48; k++) any_pix |= (cap_attr[k] != 4'd0);
        total++; if (any_stb !== 1'b0) begin bad++; $display("FAIL window_stb got=%0b want=0", any_stb); end
        total++; if (any_pix !== 1'b0) begin bad++; $display("FAIL window_attr got=%0b want=0", any_pix); end
    endtask

    task automatic test_dot9();
        dot9 = 1'b1; bus.csr_dat_i = 16'h1EC4; glyph_v = 8'hFF;
        run_line(0);
        total++; if (cap_attr[19] !== 4'd14) begin bad++; $display("FAIL dot9_pix0 got=%0d want=14", cap_attr[19]); end
        total++; if (cap_attr[27] !== 4'd14) begin bad++; $display("FAIL dot9_linegfx got=%0d want=14", cap_attr[27]); end
        total++; if ({cap_hs[14], cap_hs[15], cap_hs[16]} !== 3'b010) begin bad++; $display("FAIL hsync_delay10 got=%b want=010", {cap_hs[14], cap_hs[15], cap_hs[16]}); end
        bus.csr_dat_i = 16'h1E41;
        run_line(1);
        total++; if (cap_attr[26] !== 4'd14) begin bad++; $display("FAIL dot9_pix7 got=%0d want=14", cap_attr[26]); end
        total++; if (cap_attr[27] !== 4'd1) begin bad++; $display("FAIL dot9_bg got=%0d want=1", cap_attr[27]); end
    endtask

    task automatic test_underrun();
        logic any_pix;
        dot9 = 1'b0; bus.csr_dat_i = 16'h1E41; glyph_v = 8'h81; ack_at = 5;
        run_line(0);
        total++; if ({cap_attr[17], cap_attr[18]} !== {4'd14, 4'd1}) begin bad++; $display("FAIL late_ok_pix got=%h want=e1", {cap_attr[17], cap_attr[18]}); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL late_ok_underrun got=%0b want=0", underrun); end
        ack_at = 6;
        run_line(1);
        total++; if ({cap_stb[13], cap_stb[14]} !== 2'b10) begin bad++; $display("FAIL deadline_stb got=%b want=10", {cap_stb[13], cap_stb[14]}); end
        any_pix = 1'b0;
        for (int j = 0; j < 8; j++) any_pix |= (cap_attr[17+j] != 4'd0);
        total++; if (any_pix !== 1'b0) begin bad++; $display("FAIL underrun_blank got=%0b want=0", any_pix); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set got=%0b want=1", underrun); end
    endtask

    task automatic test_cursor();
        logic inv;
        ack_at = 1; cursor_pos = 16'h0001; cur_start = 5'd14; cur_end = 5'd15; start_addr = '0;
        while (fc_m < 9) begin
            for (int v = 0; v < 16; v++) begin
                run_line(v);
                if (v >= 13) begin
                    inv = (v >= 14) && (fc_m[3] == 1'b1);
                    total++; if (cap_attr[17] !== (inv ? 4'd1 : 4'd14)) begin bad++; $display("FAIL cursor_p0 fc=%0d scan=%0d got=%0d want=%0d", fc_m, v, cap_attr[17], inv ? 1 : 14); end
                    total++; if (cap_attr[18] !== (inv ? 4'd14 : 4'd1)) begin bad++; $display("FAIL cursor_p1 fc=%0d scan=%0d got=%0d want=%0d", fc_m, v, cap_attr[18], inv ? 14 : 1); end
                    total++; if (cap_attr[25] !== 4'd14) begin bad++; $display("FAIL cursor_other fc=%0d scan=%0d got=%0d want=14", fc_m, v, cap_attr[25]); end
                end
                if (v == 14) begin
                    total++; if (bus.font_adr_o !== {8'h41, 5'd14}) begin bad++; $display("FAIL fadr_scan got=%0h want=%0h", bus.font_adr_o, {8'h41, 5'd14}); end
                end
            end
        end
        cur_start = 5'd15; cur_end = 5'd14;
        for (int v = 0; v < 16; v++) begin
            run_line(v);
            if (v >= 14) begin
                total++; if (cap_attr[17] !== 4'd14) begin bad++; $display("FAIL cursor_off scan=%0d got=%0d want=14", v, cap_attr[17]); end
            end
        end
    endtask

    task automatic test_blink();
        cursor_pos = 16'hFFFF; bus.csr_dat_i = 16'h8F41; glyph_v = 8'h81; blink_en = 1'b0;
        run_line(0);
        total++; if ({cap_attr[17], cap_attr[18]} !== {4'd15, 4'd8}) begin bad++; $display("FAIL brightbg got=%h want=f8", {cap_attr[17], cap_attr[18]}); end
        blink_en = 1'b1;
        while (fc_m < 16) begin
            run_line(0);
            total++; if (cap_attr[17] !== ((fc_m[4] == 1'b1) ? 4'd15 : 4'd0)) begin bad++; $display("FAIL blink_fg fc=%0d got=%0d", fc_m, cap_attr[17]); end
            total++; if (cap_attr[18] !== 4'd0) begin bad++; $display("FAIL blink_bg fc=%0d got=%0d want=0", fc_m, cap_attr[18]); end
        end
    endtask

    task automatic test_reset_mid();
        blink_en = 1'b0; bus.csr_dat_i = 16'h1E41; ack_at = 99;
        for (int h = 0; h < 10; h++) begin
            hc = 10'(h); vc = 10'd1; hs_i = 1'b0; vo_i = 1'b1; bus.csr_ack_i = 1'b0;
            @(posedge clk);
            #1;
        end
        total++; if (bus.csr_stb_o !== 1'b1) begin bad++; $display("FAIL midrst_pre_stb got=%0b want=1", bus.csr_stb_o); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.csr_stb_o !== 1'b0) begin bad++; $display("FAIL midrst_stb got=%0b want=0", bus.csr_stb_o); end
        total++; if ({attr, hs_o, vo_o, underrun} !== 7'd0) begin bad++; $display("FAIL midrst_outs got=%b want=0", {attr, hs_o, vo_o, underrun}); end
        total++; if ({bus.csr_adr_o, bus.font_adr_o} !== 29'd0) begin bad++; $display("FAIL midrst_adrs got=%h want=0", {bus.csr_adr_o, bus.font_adr_o}); end
        @(posedge clk);
        #1;
        rst_n = 1'b1; fc_m = 0; start_addr = '0; ack_at = 1;
        run_line(0);
        total++; if ({cap_attr[17], cap_attr[18], cap_attr[24]} !== {4'd14, 4'd1, 4'd14}) begin bad++; $display("FAIL postrst_pix got=%h want=e1e", {cap_attr[17], cap_attr[18], cap_attr[24]}); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL postrst_underrun got=%0b want=0", underrun); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_scroll();
        test_dot9();
        test_underrun();
        test_cursor();
        test_blink();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
